// File: rtl/mem_writer_of_verifla.sv
// Run-length capture writer for a logic analyser: pre-trigger ring, trigger flush, post-trigger fill.
// Each memory word is {repeat_count, sample}.
//
// state | meaning
// IDLE  | after reset, waiting for arm
// PRE   | filling the pre-trigger ring 0..LA_TRIGGER_MATCH_MEM_ADDR-1, trigger evaluated
// POST  | filling LA_TRIGGER_MATCH_MEM_ADDR..LA_MEM_LAST_ADDR, trigger ignored
// DONE  | capture complete, outputs held until re-armed
module mem_writer_of_verifla #(
  parameter int LA_DATA_INPUT_WORDLEN_BITS = 8,
  parameter int LA_IDENTICAL_SAMPLES_BITS  = 8,
  parameter int LA_MEM_ADDRESS_BITS        = 9,
  parameter int LA_TRIGGER_MATCH_MEM_ADDR  = 256,
  parameter int LA_MEM_LAST_ADDR           = 511
) (
  input  logic                                                         clk,
  input  logic                                                         rst_l,
  input  logic [LA_DATA_INPUT_WORDLEN_BITS-1:0]                        data_in,
  input  logic                                                         arm,
  input  logic [LA_DATA_INPUT_WORDLEN_BITS-1:0]                        trigger_value,
  input  logic [LA_DATA_INPUT_WORDLEN_BITS-1:0]                        trigger_mask,
  output logic [LA_MEM_ADDRESS_BITS-1:0]                               addra,
  output logic                                                         wea,
  output logic [LA_IDENTICAL_SAMPLES_BITS+LA_DATA_INPUT_WORDLEN_BITS-1:0] dina,
  output logic                                                         capturing,
  output logic                                                         done,
  output logic                                                         pre_wrapped,
  output logic [LA_MEM_ADDRESS_BITS-1:0]                               bt_queue_tail_address
);

  localparam int W = LA_DATA_INPUT_WORDLEN_BITS;
  localparam int C = LA_IDENTICAL_SAMPLES_BITS;
  localparam int A = LA_MEM_ADDRESS_BITS;
  localparam logic [A-1:0] TRIG_ADDR = A'(LA_TRIGGER_MATCH_MEM_ADDR);
  localparam logic [A-1:0] PRE_LAST  = A'(LA_TRIGGER_MATCH_MEM_ADDR - 1);
  localparam logic [A-1:0] LAST_ADDR = A'(LA_MEM_LAST_ADDR);

  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

  state_t         state;
  logic           run_empty;
  logic           last_written;
  logic [W-1:0]   cur_data;
  logic [C-1:0]   cur_count;
  logic [A-1:0]   wr_addr;

  logic           extend_run;
  logic           trig_hit;
  logic           active;
  logic           flush;

  always_comb begin
    extend_run = (data_in == cur_data) && (cur_count != '1);
    trig_hit   = ((data_in ^ trigger_value) & trigger_mask) == '0;
    active     = ((state == PRE) || (state == POST)) && !run_empty && !last_written;
    // a trigger flushes the run even when the sample would have extended it
    flush      = active && (!extend_run || ((state == PRE) && trig_hit));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state                 <= IDLE;
      run_empty             <= 1'b1;
      last_written          <= 1'b0;
      cur_data              <= '0;
      cur_count             <= '0;
      wr_addr               <= '0;
      addra                 <= '0;
      wea                   <= 1'b0;
      dina                  <= '0;
      capturing             <= 1'b0;
      done                  <= 1'b0;
      pre_wrapped           <= 1'b0;
      bt_queue_tail_address <= '0;
    end else begin
      wea <= 1'b0;

      if (flush) begin
        wea       <= 1'b1;
        addra     <= wr_addr;
        dina      <= {cur_count, cur_data};
        cur_data  <= data_in;
        cur_count <= C'(1);
      end else if (active) begin
        cur_count <= cur_count + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state        <= PRE;
            wr_addr      <= '0;
            pre_wrapped  <= 1'b0;
            done         <= 1'b0;
            capturing    <= 1'b1;
            run_empty    <= 1'b1;
            last_written <= 1'b0;
          end
        end
        PRE: begin
          if (run_empty) begin
            cur_data  <= data_in;
            cur_count <= C'(1);
            run_empty <= 1'b0;
          end else if (trig_hit) begin
            bt_queue_tail_address <= wr_addr;
            wr_addr               <= TRIG_ADDR;
            state                 <= POST;
          end else if (flush) begin
            if (wr_addr == PRE_LAST) begin
              wr_addr     <= '0;
              pre_wrapped <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        POST: begin
          // the run still open after the last word is dropped
          if (last_written) begin
            state     <= DONE;
            done      <= 1'b1;
            capturing <= 1'b0;
            run_empty <= 1'b1;
          end else if (flush) begin
            if (wr_addr == LAST_ADDR) last_written <= 1'b1;
            else                      wr_addr      <= wr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writer_of_verifla.sv
// Self-checking bench for mem_writer_of_verifla: vector table plus directed capture sequences,
// memory writes compared through an expected-write queue.
module tb_mem_writer_of_verifla;

  logic        clk;
  logic        rst_l;
  logic [7:0]  data_in;
  logic        arm;
  logic [7:0]  trigger_value;
  logic [7:0]  trigger_mask;
  logic [8:0]  addra;
  logic        wea;
  logic [15:0] dina;
  logic        capturing;
  logic        done;
  logic        pre_wrapped;
  logic [8:0]  bt_queue_tail_address;

  int tests = 0;
  int fails = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  mem_writer_of_verifla dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .data_in               (data_in),
    .arm                   (arm),
    .trigger_value         (trigger_value),
    .trigger_mask          (trigger_mask),
    .addra                 (addra),
    .wea                   (wea),
    .dina                  (dina),
    .capturing             (capturing),
    .done                  (done),
    .pre_wrapped           (pre_wrapped),
    .bt_queue_tail_address (bt_queue_tail_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_l && wea) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d dina=%h, required no write", addra, dina);
      end else begin
        mon_e = exp_q.pop_front();
        if ({addra, dina} !== mon_e) begin
          fails++;
          $display("FAIL write: got addr=%0d dina=%h, required addr=%0d dina=%h",
                   addra, dina, mon_e[24:16], mon_e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic [7:0] d, input logic w,
                      input logic [8:0] ad, input logic [15:0] di);
    arm     = a;
    data_in = d;
    if (w) exp_q.push_back({ad, di});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_l = 1'b0;
    #2 rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addra"}, 32'(addra), 0);
    chk({tag, "_wea"}, 32'(wea), 0);
    chk({tag, "_dina"}, 32'(dina), 0);
    chk({tag, "_capturing"}, 32'(capturing), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pre_wrapped"}, 32'(pre_wrapped), 0);
    chk({tag, "_tail"}, 32'(bt_queue_tail_address), 0);
  endtask

  typedef struct {
    logic        arm;
    logic [7:0]  d;
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] dina;
    logic        cap;
    logic [8:0]  tail;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // trigger: upper nibble == 0xE
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd0};
    tbl[1]  = '{1'b1, 8'hE1, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd0};
    tbl[2]  = '{1'b0, 8'h11, 1'b1, 9'd0,   16'h01E1, 1'b1, 9'd0};
    tbl[3]  = '{1'b0, 8'h11, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd0};
    tbl[4]  = '{1'b0, 8'h22, 1'b1, 9'd1,   16'h0211, 1'b1, 9'd0};
    tbl[5]  = '{1'b0, 8'h22, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd0};
    tbl[6]  = '{1'b0, 8'h22, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd0};
    tbl[7]  = '{1'b0, 8'h33, 1'b1, 9'd2,   16'h0322, 1'b1, 9'd0};
    tbl[8]  = '{1'b0, 8'hE5, 1'b1, 9'd3,   16'h0133, 1'b1, 9'd3};
    tbl[9]  = '{1'b0, 8'hE5, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd3};
    tbl[10] = '{1'b0, 8'hEE, 1'b1, 9'd256, 16'h02E5, 1'b1, 9'd3};
    tbl[11] = '{1'b1, 8'hEE, 1'b0, 9'd0,   16'h0000, 1'b1, 9'd3};
    tbl[12] = '{1'b0, 8'h01, 1'b1, 9'd257, 16'h02EE, 1'b1, 9'd3};

    rst_l = 1'b0;
    arm = 1'b0;
    data_in = 8'h00;
    trigger_value = 8'h00;
    trigger_mask = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // vector table
    trigger_value = 8'hE0;
    trigger_mask  = 8'hF0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].arm, tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].dina);
      chk($sformatf("tbl%0d_capturing", i), 32'(capturing), 32'(tbl[i].cap));
      chk($sformatf("tbl%0d_tail", i), 32'(bt_queue_tail_address), 32'(tbl[i].tail));
    end

    // saturation: 256 identical samples
    do_reset();
    trigger_value = 8'hEE;
    trigger_mask  = 8'hFF;
    step(1'b1, 8'hA5, 1'b0, 9'd0, 16'h0);
    for (int i = 0; i < 255; i++) step(1'b0, 8'hA5, 1'b0, 9'd0, 16'h0);
    step(1'b0, 8'hA5, 1'b1, 9'd0, 16'hFFA5);
    step(1'b0, 8'h3C, 1'b1, 9'd1, 16'h01A5);

    // saturation coinciding with trigger: single flush write
    do_reset();
    trigger_value = 8'h00;
    step(1'b1, 8'hA5, 1'b0, 9'd0, 16'h0);
    for (int i = 0; i < 255; i++) step(1'b0, 8'hA5, 1'b0, 9'd0, 16'h0);
    trigger_value = 8'hA5;
    step(1'b0, 8'hA5, 1'b1, 9'd0, 16'hFFA5);
    trigger_value = 8'h00;
    step(1'b0, 8'hA5, 1'b0, 9'd0, 16'h0);
    step(1'b0, 8'h3C, 1'b1, 9'd256, 16'h02A5);
    chk("sat_trig_capturing", 32'(capturing), 1);

    // pre-trigger ring wrap, trigger, full post fill
    do_reset();
    trigger_value = 8'h01;
    trigger_mask  = 8'h01;
    step(1'b1, 8'h00, 1'b0, 9'd0, 16'h0);
    for (int k = 0; k <= 257; k++) begin
      step(1'b0, 8'(2 * k), k >= 1, 9'((k - 1) % 256), {8'h01, 8'(2 * (k - 1))});
      if (k == 255) chk("wrap_before", 32'(pre_wrapped), 0);
      if (k == 256) chk("wrap_after", 32'(pre_wrapped), 1);
    end
    step(1'b0, 8'h01, 1'b1, 9'd1, {8'h01, 8'(2 * 257)});
    chk("post_tail", 32'(bt_queue_tail_address), 1);
    for (int j = 1; j <= 256; j++)
      step(1'b0, 8'(2 * j), 1'b1, 9'(255 + j), {8'h01, (j == 1) ? 8'h01 : 8'(2 * (j - 1))});
    chk("done_not_yet", 32'(done), 0);
    chk("cap_not_yet", 32'(capturing), 1);
    step(1'b0, 8'hFF, 1'b0, 9'd0, 16'h0);
    chk("done_set", 32'(done), 1);
    chk("cap_cleared", 32'(capturing), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'(i * 3 + 5), 1'b0, 9'd0, 16'h0);
    chk("done_held", 32'(done), 1);
    chk("wrap_held", 32'(pre_wrapped), 1);
    chk("tail_held", 32'(bt_queue_tail_address), 1);

    // re-arm from DONE, trigger, reset mid-POST at address 300
    step(1'b1, 8'h00, 1'b0, 9'd0, 16'h0);
    chk("rearm_done", 32'(done), 0);
    chk("rearm_wrap", 32'(pre_wrapped), 0);
    chk("rearm_cap", 32'(capturing), 1);
    step(1'b0, 8'h10, 1'b0, 9'd0, 16'h0);
    step(1'b0, 8'h12, 1'b1, 9'd0, 16'h0110);
    step(1'b0, 8'h13, 1'b1, 9'd1, 16'h0112);
    chk("rearm_tail", 32'(bt_queue_tail_address), 1);
    for (int j = 1; j <= 45; j++)
      step(1'b0, 8'(2 * j), 1'b1, 9'(255 + j), {8'h01, (j == 1) ? 8'h13 : 8'(2 * (j - 1))});
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1 chk_all_zero("midpost_reset");
    #1 rst_l = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'(8'h50 + i), 1'b0, 9'd0, 16'h0);
    chk("idle_no_capture", 32'(capturing), 0);
    step(1'b1, 8'h00, 1'b0, 9'd0, 16'h0);
    chk("restart_cap", 32'(capturing), 1);
    step(1'b0, 8'h40, 1'b0, 9'd0, 16'h0);
    step(1'b0, 8'h42, 1'b1, 9'd0, 16'h0140);

    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_writer_of_verifla.md
MEM_WRITER_OF_VERIFLA -- requirements
Module: mem_writer_of_verifla

Interface
REQ-001 SHALL have parameter LA_DATA_INPUT_WORDLEN_BITS, default 8, width of the probed sample.
REQ-002 SHALL have parameter LA_IDENTICAL_SAMPLES_BITS, default 8, width of the run-length repeat count.
REQ-003 SHALL have parameter LA_MEM_ADDRESS_BITS, default 9, capture memory address width.
REQ-004 SHALL have parameter LA_TRIGGER_MATCH_MEM_ADDR, default 256, first post-trigger address; pre-trigger ring is 0..LA_TRIGGER_MATCH_MEM_ADDR-1.
REQ-005 SHALL have parameter LA_MEM_LAST_ADDR, default 511, last post-trigger address.
REQ-006 Ports: clk  input  1  sole clock, all logic on rising edge.
REQ-007 Ports: rst_l  input  1  asynchronous active-low reset.
REQ-008 Ports: data_in  input  LA_DATA_INPUT_WORDLEN_BITS  probed sample, taken every clk.
REQ-009 Ports: arm  input  1  starts a capture, level sampled per clk.
REQ-010 Ports: trigger_value, trigger_mask  input  LA_DATA_INPUT_WORDLEN_BITS each  trigger pattern and care-bits.
REQ-011 Ports: addra  output  LA_MEM_ADDRESS_BITS; wea  output  1; dina  output  LA_IDENTICAL_SAMPLES_BITS+LA_DATA_INPUT_WORDLEN_BITS  memory write port.
REQ-012 Ports: capturing  output  1; done  output  1; pre_wrapped  output  1; bt_queue_tail_address  output  LA_MEM_ADDRESS_BITS  last pre-trigger word address.

Function
REQ-013 SHALL implement states IDLE, PRE, POST, DONE; all outputs registered.
REQ-014 IDLE or DONE with arm=1 -> PRE: wr_addr=0, pre_wrapped=0, done=0, capturing=1, run empty; arm in PRE/POST ignored.
REQ-015 First PRE cycle SHALL only load the run: cur_data=data_in, cur_count=1; no trigger evaluation, no write.
REQ-016 Subsequent PRE/POST cycles: if data_in==cur_data and cur_count!=all-ones, cur_count++ with no write.
REQ-017 Else (data change or saturated count): wea=1, addra=wr_addr, dina={cur_count,cur_data} registered on that edge; cur_data=data_in, cur_count=1; wr_addr advances.
REQ-018 wea SHALL be high exactly one cycle per word; memory stores on the following edge; wea=0 on all non-write cycles, dina/addra hold last value.
REQ-019 Trigger in PRE (after the first cycle): (data_in & trigger_mask)==(trigger_value & trigger_mask).
REQ-020 On trigger: unconditional flush of current run to wr_addr (even if data unchanged), bt_queue_tail_address=that address, wr_addr=LA_TRIGGER_MATCH_MEM_ADDR, trigger sample starts new run with count 1, state=POST.
REQ-021 PRE ring: write at LA_TRIGGER_MATCH_MEM_ADDR-1 wraps wr_addr to 0 and sets pre_wrapped=1 (sticky until next arm).
REQ-022 POST: trigger not evaluated; RLE per REQ-016/017; the write to LA_MEM_LAST_ADDR SHALL be the final write, then state=DONE, done=1, capturing=0 on the next edge; unflushed run discarded.
REQ-023 DONE: wea=0, outputs held until arm.
REQ-024 Simultaneous saturation and trigger SHALL produce a single flush write (REQ-020).
REQ-025 Block SHALL never write memory contents outside IDLE->DONE capture; it does not clear memory.

Reset
REQ-026 rst_l=0 at any time (including mid-PRE/POST) SHALL asynchronously force IDLE, addra=0, wea=0, dina=0, capturing=0, done=0, pre_wrapped=0, bt_queue_tail_address=0, run empty.
REQ-027 After rst_l deasserts, no write SHALL occur until arm=1.

Verification
REQ-028 Arm, data_in=0xA5 for 256 cycles then 0x3C, mask=0xFF value=0xEE -> one write {0xFF,0xA5} at addr 0, then new run of 0xA5 count 1.
REQ-029 Arm, data_in=0x01 for 10 cycles then 0xEE, mask=0xFF value=0xEE -> write {0x0A,0x01} at addr 0, bt_queue_tail_address=0, state POST, next write at 256.
REQ-030 Arm, data_in incrementing every cycle, no trigger match -> writes 0..255 then 0, pre_wrapped=1 after addr 255 write.
REQ-031 After trigger, data_in changes every cycle -> writes 256..511 each with count 1, done=1 one edge after addr-511 write, wea stays 0 thereafter.
REQ-032 rst_l pulsed low mid-POST at addr 300 -> all outputs 0 immediately, IDLE; arm during PRE ignored; arm in DONE restarts at addr 0.
